// File: rtl/rob_tag_table_pkg.sv
// Shared sizing and types for the register-status (rename) table.
// The ROB, forward unit and decode import the same widths from here.
package rob_tag_table_pkg;
  localparam int NUM_REGS        = 32;
  localparam int REG_ADDR_WIDTH  = $clog2(NUM_REGS);
  localparam int ROB_ENTRY_WIDTH = 4;

  typedef logic [REG_ADDR_WIDTH-1:0]  reg_addr_t;
  typedef logic [ROB_ENTRY_WIDTH-1:0] rob_id_t;
endpackage

// File: rtl/rob_tag_table_if.sv
// Decode read ports, dispatch alloc, ROB commit and flush for the rename table.
interface rob_tag_table_if;
  import rob_tag_table_pkg::*;

  reg_addr_t             rs1_addr;
  reg_addr_t             rs2_addr;
  rob_id_t               rs1_rob_entry;
  logic                  rs1_rob_entry_valid;
  rob_id_t               rs2_rob_entry;
  logic                  rs2_rob_entry_valid;
  logic                  alloc_en;
  reg_addr_t             alloc_rd;
  rob_id_t               alloc_rob_id;
  logic                  commit_en;
  reg_addr_t             commit_rd;
  rob_id_t               commit_rob_id;
  logic                  flush;
  logic [NUM_REGS-1:0]   busy_vector;

  modport master (
    output rs1_addr, rs2_addr, alloc_en, alloc_rd, alloc_rob_id,
           commit_en, commit_rd, commit_rob_id, flush,
    input  rs1_rob_entry, rs1_rob_entry_valid, rs2_rob_entry, rs2_rob_entry_valid,
           busy_vector
  );

  modport slave (
    input  rs1_addr, rs2_addr, alloc_en, alloc_rd, alloc_rob_id,
           commit_en, commit_rd, commit_rob_id, flush,
    output rs1_rob_entry, rs1_rob_entry_valid, rs2_rob_entry, rs2_rob_entry_valid,
           busy_vector
  );
endinterface

// File: rtl/rob_tag_entry.sv
// One architectural register's mapping: producer ROB tag plus valid bit.
// Update order: rst, flush, alloc, commit; alloc beats commit so the newer producer survives.
module rob_tag_entry
  import rob_tag_table_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    alloc_hit,
  input  logic    commit_hit,
  input  rob_id_t alloc_rob_id,
  output rob_id_t tag,
  output logic    valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (alloc_hit) begin
      tag   <= alloc_rob_id;
      valid <= 1'b1;
    end else if (commit_hit) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rob_tag_table.sv
// Rename table: per-register youngest in-flight producer, read combinationally by decode.
// x0 has no entry; its slot is tied off so reads of x0 come back invalid/zero.
module rob_tag_table
  import rob_tag_table_pkg::*;
(
  input logic             clk,
  input logic             rst,
  rob_tag_table_if.slave  bus
);
  rob_id_t [NUM_REGS-1:0] tags;
  logic    [NUM_REGS-1:0] valid;

  assign tags[0]  = '0;
  assign valid[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic alloc_hit, commit_hit;
    // A commit only retires the mapping if it still names this producer; a younger
    // rename leaves a stale commit with nothing to clear.
    assign alloc_hit  = bus.alloc_en  && (bus.alloc_rd  == reg_addr_t'(r));
    assign commit_hit = bus.commit_en && (bus.commit_rd == reg_addr_t'(r)) &&
                        valid[r] && (tags[r] == bus.commit_rob_id);

    rob_tag_entry u_entry (
      .clk          (clk),
      .rst          (rst),
      .flush        (bus.flush),
      .alloc_hit    (alloc_hit),
      .commit_hit   (commit_hit),
      .alloc_rob_id (bus.alloc_rob_id),
      .tag          (tags[r]),
      .valid        (valid[r])
    );
  end

  // Invalid mappings read as zero rather than exposing the stale tag.
  assign bus.rs1_rob_entry_valid = valid[bus.rs1_addr];
  assign bus.rs1_rob_entry       = valid[bus.rs1_addr] ? tags[bus.rs1_addr] : '0;
  assign bus.rs2_rob_entry_valid = valid[bus.rs2_addr];
  assign bus.rs2_rob_entry       = valid[bus.rs2_addr] ? tags[bus.rs2_addr] : '0;
  assign bus.busy_vector         = valid;
endmodule
